// File: rtl/word_uart_streamer_if.sv
// Capture, step-control, UART handshake and status signals of word_uart_streamer.
// The master modport is the streamer side; the slave modport is the router/UART side.
interface word_uart_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB + 1);

  logic                  cap_en;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  step_mode;
  logic                  step;
  logic [7:0]            tx_byte;
  logic                  tx_send_en;
  logic                  tx_done;
  logic                  busy;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  overflow;
  logic [IW-1:0]         byte_idx;
  logic [15:0]           words_sent;

  modport master (
    input  cap_en, cap_data, step_mode, step, tx_done,
    output tx_byte, tx_send_en, busy, fifo_empty, fifo_full, overflow,
           byte_idx, words_sent
  );

  modport slave (
    output cap_en, cap_data, step_mode, step, tx_done,
    input  tx_byte, tx_send_en, busy, fifo_empty, fifo_full, overflow,
           byte_idx, words_sent
  );
endinterface

// File: rtl/word_uart_streamer.sv
// Buffers payload words in a FIFO and streams them byte by byte into a UART byte transmitter.
// Optional macro WORD_UART_CSUM_EN appends an XOR checksum byte after each word.
module word_uart_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                clk,
  input  logic                nreset,
  word_uart_streamer_if.master bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
`ifdef WORD_UART_CSUM_EN
  localparam int LAST = NB;
`else
  localparam int LAST = NB - 1;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head, shreg;
  logic [IW-1:0]         byte_idx;
  logic [15:0]           words_sent;
  logic                  overflow, manual;
  logic                  empty, full, pop, push, send_fire, last_byte;
  logic [7:0]            data_byte;

`ifdef WORD_UART_CSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NB; i++) acc = acc ^ w[8*i +: 8];
    return acc;
  endfunction
`endif

  // Extra pointer bit distinguishes full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr - rd_ptr) == FULL_CNT);
  assign pop       = (state == S_LOAD);
  assign push      = bus.cap_en && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign send_fire = (state == S_SEND) && (!manual || bus.step);
  assign last_byte = (byte_idx == LAST_IDX);
  assign data_byte = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1 -: 8] : shreg[7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.cap_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.cap_en && full && !pop) overflow <= 1'b1;
    end
  end

  // Word shift register and per-word counters
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg      <= '0;
      byte_idx   <= '0;
      words_sent <= '0;
      manual     <= 1'b0;
`ifdef WORD_UART_CSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      if (state == S_LOAD) begin
        shreg    <= head;
        byte_idx <= '0;
`ifdef WORD_UART_CSUM_EN
        csum     <= xor_bytes(head);
`endif
      end else if (state == S_WAIT && bus.tx_done) begin
        if (last_byte) begin
          words_sent <= words_sent + 16'd1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          shreg    <= (MSB_FIRST != 0) ? (shreg << 8) : (shreg >> 8);
        end
      end
      // Step mode is latched once per byte, on entry to SEND
      if (state_next == S_SEND && state != S_SEND) manual <= bus.step_mode;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_LOAD;
      S_LOAD:  state_next = S_SEND;
      S_SEND:  if (send_fire) state_next = S_WAIT;
      S_WAIT:  if (bus.tx_done) state_next = last_byte ? S_IDLE : S_SEND;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != S_IDLE);
    bus.tx_send_en = send_fire;
`ifdef WORD_UART_CSUM_EN
    bus.tx_byte    = (byte_idx == IW'(NB)) ? csum : data_byte;
`else
    bus.tx_byte    = data_byte;
`endif
  end

  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.overflow   = overflow;
  assign bus.byte_idx   = byte_idx;
  assign bus.words_sent = words_sent;
endmodule

// File: tb/tb_word_uart_streamer.sv
// Scoreboard bench for word_uart_streamer: two instances (MSB-first and LSB-first) with a
// modelled UART that answers each tx_send_en with tx_done a fixed delay later.
module tb_word_uart_streamer;
  localparam int DW       = 32;
  localparam int IW       = $clog2(DW / 8 + 1);
  localparam int DONE_DLY = 10;
`ifdef WORD_UART_CSUM_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  word_uart_streamer_if #(.DATA_WIDTH(DW)) if0 ();
  word_uart_streamer_if #(.DATA_WIDTH(DW)) if1 ();

  word_uart_streamer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut0 (
    .clk(clk), .nreset(nreset), .bus(if0)
  );
  word_uart_streamer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut1 (
    .clk(clk), .nreset(nreset), .bus(if1)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b0 [$];
  logic [7:0] exp_b1 [$];
  int         exp_i0 [$];
  int         exp_i1 [$];

  int         sent0 = 0, sent1 = 0, done0 = 0, done1 = 0;
  int         cnt0 = 0, cnt1 = 0, max_idx0 = 0;
  bit         pend0 = 0, pend1 = 0, hold0 = 0, hold1 = 0;
  logic [7:0] last0, last1, eb0, eb1;
  int         ei0, ei1;

  // UART model + scoreboard for instance 0
  always @(negedge clk) begin
    if (nreset !== 1'b1) begin
      pend0       = 0;
      if0.tx_done = 1'b0;
    end else begin
      if0.tx_done = 1'b0;
      if (if0.tx_send_en === 1'b1) begin
        sent0++;
        last0 = if0.tx_byte;
        pend0 = 1;
        cnt0  = DONE_DLY - 1;
        if (int'(if0.byte_idx) > max_idx0) max_idx0 = int'(if0.byte_idx);
        checks++;
        if (exp_b0.size() == 0) begin
          errors++;
          $display("FAIL send0_unexpected: got byte %02h idx %0d, required no send", if0.tx_byte, if0.byte_idx);
        end else begin
          eb0 = exp_b0.pop_front();
          ei0 = exp_i0.pop_front();
          if (if0.tx_byte !== eb0 || if0.byte_idx !== ei0[IW-1:0]) begin
            errors++;
            $display("FAIL send0_byte: got %02h idx %0d, required %02h idx %0d", if0.tx_byte, if0.byte_idx, eb0, ei0);
          end
        end
      end else if (pend0 && !hold0) begin
        if (cnt0 == 0) begin
          checks++;
          if (if0.tx_byte !== last0) begin
            errors++;
            $display("FAIL stable0: tx_byte %02h at tx_done, required %02h", if0.tx_byte, last0);
          end
          if0.tx_done = 1'b1;
          pend0       = 0;
          done0++;
        end else cnt0--;
      end
    end
  end

  // UART model + scoreboard for instance 1
  always @(negedge clk) begin
    if (nreset !== 1'b1) begin
      pend1       = 0;
      if1.tx_done = 1'b0;
    end else begin
      if1.tx_done = 1'b0;
      if (if1.tx_send_en === 1'b1) begin
        sent1++;
        last1 = if1.tx_byte;
        pend1 = 1;
        cnt1  = DONE_DLY - 1;
        checks++;
        if (exp_b1.size() == 0) begin
          errors++;
          $display("FAIL send1_unexpected: got byte %02h idx %0d, required no send", if1.tx_byte, if1.byte_idx);
        end else begin
          eb1 = exp_b1.pop_front();
          ei1 = exp_i1.pop_front();
          if (if1.tx_byte !== eb1 || if1.byte_idx !== ei1[IW-1:0]) begin
            errors++;
            $display("FAIL send1_byte: got %02h idx %0d, required %02h idx %0d", if1.tx_byte, if1.byte_idx, eb1, ei1);
          end
        end
      end else if (pend1 && !hold1) begin
        if (cnt1 == 0) begin
          checks++;
          if (if1.tx_byte !== last1) begin
            errors++;
            $display("FAIL stable1: tx_byte %02h at tx_done, required %02h", if1.tx_byte, last1);
          end
          if1.tx_done = 1'b1;
          pend1       = 0;
          done1++;
        end else cnt1--;
      end
    end
  end

  task automatic push_exp(input int which, input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = (which == 0) ? w[31-8*i -: 8] : w[8*i +: 8];
      if (which == 0) begin exp_b0.push_back(b); exp_i0.push_back(i); end
      else            begin exp_b1.push_back(b); exp_i1.push_back(i); end
    end
`ifdef WORD_UART_CSUM_EN
    b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    if (which == 0) begin exp_b0.push_back(b); exp_i0.push_back(4); end
    else            begin exp_b1.push_back(b); exp_i1.push_back(4); end
`endif
  endtask

  task automatic capture(input int which, input logic [31:0] w, input bit kept);
    @(negedge clk);
    if (which == 0) begin if0.cap_en = 1'b1; if0.cap_data = w; end
    else            begin if1.cap_en = 1'b1; if1.cap_data = w; end
    if (kept) push_exp(which, w);
    @(negedge clk);
    if0.cap_en = 1'b0;
    if1.cap_en = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    if0.step = 1'b1;
    @(negedge clk);
    if0.step = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (n < 3000 && !((which == 0) ? (exp_b0.size() == 0 && !pend0 && if0.busy === 1'b0)
                                      : (exp_b1.size() == 0 && !pend1 && if1.busy === 1'b0))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain%0d: timed out with %0d bytes still required", which,
               (which == 0) ? exp_b0.size() : exp_b1.size());
    end
  endtask

  task automatic test_reset();
    checks += 8;
    if (if0.tx_byte !== 8'h00)    begin errors++; $display("FAIL rst_tx_byte: got %h, required 00", if0.tx_byte); end
    if (if0.tx_send_en !== 1'b0)  begin errors++; $display("FAIL rst_send_en: got %b, required 0", if0.tx_send_en); end
    if (if0.busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b, required 0", if0.busy); end
    if (if0.overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %b, required 0", if0.overflow); end
    if (if0.byte_idx !== '0)      begin errors++; $display("FAIL rst_byte_idx: got %0d, required 0", if0.byte_idx); end
    if (if0.words_sent !== 16'd0) begin errors++; $display("FAIL rst_words_sent: got %0d, required 0", if0.words_sent); end
    if (if0.fifo_empty !== 1'b1)  begin errors++; $display("FAIL rst_fifo_empty: got %b, required 1", if0.fifo_empty); end
    if (if0.fifo_full !== 1'b0)   begin errors++; $display("FAIL rst_fifo_full: got %b, required 0", if0.fifo_full); end
  endtask

  task automatic test_auto_msb();
    int s, n;
    s = sent0;
    capture(0, 32'hA1B2C3D4, 1);
    n = 1;
    while (if0.tx_send_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL auto_latency: first tx_send_en after %0d cycles, required 3", n); end
    drain(0);
    checks += 3;
    if (sent0 - s != BPW)          begin errors++; $display("FAIL auto_pulses: got %0d, required %0d", sent0 - s, BPW); end
    if (if0.words_sent !== 16'd1)  begin errors++; $display("FAIL auto_words_sent: got %0d, required 1", if0.words_sent); end
    if (if0.busy !== 1'b0)         begin errors++; $display("FAIL auto_busy: got %b, required 0", if0.busy); end
  endtask

  task automatic test_lsb_first();
    int s;
    s = sent1;
    capture(1, 32'h11223344, 1);
    drain(1);
    checks += 2;
    if (sent1 - s != BPW)         begin errors++; $display("FAIL lsb_pulses: got %0d, required %0d", sent1 - s, BPW); end
    if (if1.words_sent !== 16'd1) begin errors++; $display("FAIL lsb_words_sent: got %0d, required 1", if1.words_sent); end
  endtask

  task automatic test_overflow();
    int s;
    logic [15:0] ws;
    s  = sent0;
    ws = if0.words_sent;
    hold0 = 1;
    for (int i = 1; i <= 6; i++) capture(0, 32'(i), i <= 5);
    @(negedge clk);
    checks += 3;
    if (if0.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b, required 1", if0.fifo_full); end
    if (if0.overflow !== 1'b1)  begin errors++; $display("FAIL ovf_flag: got %b, required 1", if0.overflow); end
    if (sent0 - s != 1)         begin errors++; $display("FAIL ovf_held_sends: got %0d, required 1", sent0 - s); end
    hold0 = 0;
    drain(0);
    checks += 3;
    if (if0.words_sent !== ws + 16'd5) begin errors++; $display("FAIL ovf_words_sent: got %0d, required %0d", if0.words_sent, ws + 16'd5); end
    if (if0.overflow !== 1'b1)         begin errors++; $display("FAIL ovf_sticky: got %b, required 1", if0.overflow); end
    if (if0.fifo_empty !== 1'b1)       begin errors++; $display("FAIL ovf_empty: got %b, required 1", if0.fifo_empty); end
  endtask

  task automatic test_manual();
    int s, d, n;
    logic [15:0] ws;
    s  = sent0;
    ws = if0.words_sent;
    if0.step_mode = 1'b1;
    capture(0, 32'hDEADBEEF, 1);
    repeat (100) @(negedge clk);
    checks += 2;
    if (sent0 != s)         begin errors++; $display("FAIL man_no_step: got %0d sends, required 0", sent0 - s); end
    if (if0.busy !== 1'b1)  begin errors++; $display("FAIL man_busy: got %b, required 1", if0.busy); end
    for (int b = 0; b < BPW; b++) begin
      d = done0;
      pulse_step();
      repeat (2) @(negedge clk);
      pulse_step();
      n = 0;
      while (done0 == d && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (sent0 - s != b + 1) begin errors++; $display("FAIL man_step%0d: got %0d sends, required %0d", b, sent0 - s, b + 1); end
    end
    drain(0);
    if0.step_mode = 1'b0;
    checks++;
    if (if0.words_sent !== ws + 16'd1) begin errors++; $display("FAIL man_words_sent: got %0d, required %0d", if0.words_sent, ws + 16'd1); end
  endtask

  task automatic test_csum();
    max_idx0 = 0;
    capture(0, 32'h01020408, 1);
    drain(0);
    checks++;
    if (max_idx0 != BPW - 1) begin errors++; $display("FAIL csum_max_idx: got %0d, required %0d", max_idx0, BPW - 1); end
  endtask

  task automatic test_reset_midword();
    int s, n;
    s = sent0;
    capture(0, 32'h12345678, 1);
    n = 0;
    while (sent0 - s < 2 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    #1;
    exp_b0.delete();
    exp_i0.delete();
    checks += 7;
    if (if0.tx_byte !== 8'h00)    begin errors++; $display("FAIL mid_tx_byte: got %h, required 00", if0.tx_byte); end
    if (if0.tx_send_en !== 1'b0)  begin errors++; $display("FAIL mid_send_en: got %b, required 0", if0.tx_send_en); end
    if (if0.busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b, required 0", if0.busy); end
    if (if0.overflow !== 1'b0)    begin errors++; $display("FAIL mid_overflow: got %b, required 0", if0.overflow); end
    if (if0.byte_idx !== '0)      begin errors++; $display("FAIL mid_byte_idx: got %0d, required 0", if0.byte_idx); end
    if (if0.words_sent !== 16'd0) begin errors++; $display("FAIL mid_words_sent: got %0d, required 0", if0.words_sent); end
    if (if0.fifo_empty !== 1'b1)  begin errors++; $display("FAIL mid_fifo_empty: got %b, required 1", if0.fifo_empty); end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    capture(0, 32'h55AA55AA, 1);
    drain(0);
    checks++;
    if (if0.words_sent !== 16'd1) begin errors++; $display("FAIL mid_restart_words: got %0d, required 1", if0.words_sent); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset        = 1'b0;
    if0.cap_en    = 1'b0; if0.cap_data = '0; if0.step_mode = 1'b0; if0.step = 1'b0;
    if1.cap_en    = 1'b0; if1.cap_data = '0; if1.step_mode = 1'b0; if1.step = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    test_auto_msb();
    test_lsb_first();
    test_overflow();
    test_manual();
    test_csum();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_uart_streamer.md
Name: word_uart_streamer

Overview:
- Captures DATA_WIDTH-bit router payload words into a small FIFO.
- Splits each word into bytes and feeds them one at a time to the existing UART byte transmitter through its send_en/Tx_Done handshake.
- Replaces manual per-byte key stepping with an automatic stream mode; a manual step mode is kept for board debug.
- Sits between the router output and the uart_byte_tx instance in the board top level.

Parameters:
- DATA_WIDTH, 32: payload width; must be a multiple of 8, range 8..128. NB = DATA_WIDTH/8.
- FIFO_DEPTH, 4: number of words buffered; power of 2, minimum 2.
- MSB_FIRST, 1: 1 sends byte [DATA_WIDTH-1 -: 8] first; 0 sends byte [7:0] first.

Ports:
- clk  in  1  system clock
- nreset  in  1  reset, asynchronous, active-low
- cap_en  in  1  single-cycle pulse; write cap_data into the FIFO
- cap_data  in  DATA_WIDTH  word to capture
- step_mode  in  1  0 = auto (stream every byte); 1 = manual (one byte per step pulse)
- step  in  1  single-cycle pulse; releases the next byte in manual mode
- tx_byte  out  8  byte presented to the UART transmitter
- tx_send_en  out  1  one-cycle pulse; starts a UART byte
- tx_done  in  1  one-cycle pulse from the UART transmitter; byte finished
- busy  out  1  high whenever state is not IDLE
- fifo_empty  out  1  FIFO holds no words
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- overflow  out  1  sticky; set when a capture is dropped
- byte_idx  out  $clog2(NB+1)  index of the current byte within the word
- words_sent  out  16  count of completed words; wraps around

Behaviour:
- Reset values:
  - tx_byte = 0, tx_send_en = 0, busy = 0, overflow = 0, byte_idx = 0, words_sent = 0.
  - fifo_empty = 1, fifo_full = 0, FSM in IDLE.
  - FIFO pointers cleared; FIFO contents are not reset.
- Capture:
  - cap_en with FIFO not full: word written on that clock edge; fifo_empty deasserts the next cycle.
  - cap_en with FIFO full and no pop in the same cycle: word dropped, overflow set. overflow clears only on reset.
  - cap_en and pop in the same cycle while full: capture accepted, occupancy unchanged.
- FSM states:
  - IDLE: when FIFO not empty, go to LOAD.
  - LOAD (1 cycle): pop the head word into a shift register; byte_idx = 0; go to SEND.
  - SEND:
    - Auto mode: assert tx_send_en for exactly 1 cycle with tx_byte valid in that same cycle, then go to WAIT.
    - Manual mode: hold in SEND until step, then pulse tx_send_en, then go to WAIT.
    - step is ignored in auto mode and outside SEND.
  - WAIT: hold until tx_done.
    - If byte_idx == last index: words_sent increments, go to IDLE.
    - Otherwise: byte_idx increments, shift register advances 8 bits, go to SEND.
- Timing:
  - tx_byte stays stable from the tx_send_en cycle until the cycle after tx_done.
  - tx_done outside WAIT is ignored.
- Latency, auto mode: capture into an empty FIFO gives the first tx_send_en 3 cycles later (FIFO write, IDLE, LOAD, then SEND).
- step_mode is sampled on entry to each SEND. A mode change mid-word applies from the next byte.
- Back-to-back words: after the last tx_done, go to IDLE then LOAD. There is no extra gap beyond those 2 cycles.
- words_sent wraps from 16'hFFFF to 0.
- Reset mid-word: state, FIFO and counters clear immediately and tx_send_en drops. A UART byte already in flight is not tracked.

Optional Feature:
- Macro: WORD_UART_CSUM_EN.
- Defined:
  - After the last data byte, the block sends one extra byte through the same SEND/WAIT handshake. Its value is the XOR of all NB data bytes.
  - byte_idx reaches NB for this byte.
  - Manual mode needs a step pulse for the checksum byte too.
  - words_sent increments only after the checksum byte's tx_done.
- Not defined: exactly NB bytes per word; the last index is NB-1.

Test Plan:
- Auto mode, DATA_WIDTH=32, MSB_FIRST=1, capture 32'hA1B2C3D4, tx_done returned 10 cycles after each tx_send_en -> tx_byte sequence A1,B2,C3,D4, 4 tx_send_en pulses, words_sent=1, busy low after the last tx_done.
- MSB_FIRST=0, capture 32'h11223344 -> bytes sent 44,33,22,11.
- FIFO_DEPTH=4, tx_done withheld, 6 captures 1..6 -> word 1 is popped at LOAD, words 2..5 fill the FIFO, word 6 is dropped; fifo_full=1, overflow=1. Releasing tx_done -> words 1..5 sent in order, words_sent=5.
- Manual mode, capture 32'hDEADBEEF, no step for 100 cycles -> no tx_send_en. 4 step pulses, each after the previous tx_done -> DE,AD,BE,EF. Extra step pulses during WAIT are ignored.
- WORD_UART_CSUM_EN, capture 32'h0102_0408 -> bytes 01,02,04,08,0F; byte_idx reaches 4.
- Assert nreset during WAIT of byte 2 -> all outputs return to reset values. The next capture of 32'h55AA55AA streams from byte_idx 0.
